// File: rtl/mvm_engine.sv
// Matrix-vector multiply engine: one shared vector memory, one matrix memory per output lane,
// four-stage read/multiply/reduce/accumulate pipeline with output backpressure. `MVM_SAT_EN selects saturating accumulation.
module mvm_engine #(
   parameter int unsigned IWIDTH        = 8,
   parameter int unsigned OWIDTH        = 32,
   parameter int unsigned NUM_ELEMS     = 8,
   parameter int unsigned VEC_MEM_DEPTH = 16,
   parameter int unsigned MAT_MEM_DEPTH = 64,
   parameter int unsigned NUM_OLANES    = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [IWIDTH*NUM_ELEMS-1:0]           i_vec_wdata,
   input  logic [$clog2(VEC_MEM_DEPTH)-1:0]      i_vec_waddr,
   input  logic                                  i_vec_wen,
   input  logic [IWIDTH*NUM_ELEMS-1:0]           i_mat_wdata,
   input  logic [$clog2(MAT_MEM_DEPTH)-1:0]      i_mat_waddr,
   input  logic [NUM_OLANES-1:0]                 i_mat_wen,
   input  logic                                  i_start,
   input  logic [$clog2(VEC_MEM_DEPTH)-1:0]      i_vec_start_addr,
   input  logic [$clog2(VEC_MEM_DEPTH):0]        i_vec_num_words,
   input  logic [$clog2(MAT_MEM_DEPTH)-1:0]      i_mat_start_addr,
   input  logic [$clog2(MAT_MEM_DEPTH):0]        i_mat_num_rows_per_olane,
   input  logic                                  i_ready,
   output logic                                  o_busy,
   output logic                                  o_done,
   output logic [NUM_OLANES*OWIDTH-1:0]          o_result,
   output logic                                  o_valid
);

   localparam int unsigned MEM_DATAW = IWIDTH * NUM_ELEMS;
   localparam int unsigned VEC_ADDRW = $clog2(VEC_MEM_DEPTH);
   localparam int unsigned MAT_ADDRW = $clog2(MAT_MEM_DEPTH);
   localparam int unsigned WCW       = VEC_ADDRW + 1;
   localparam int unsigned RCW       = MAT_ADDRW + 1;
   localparam int unsigned PW        = 2 * IWIDTH;
   localparam int unsigned TW        = PW + $clog2(NUM_ELEMS);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

   logic [MEM_DATAW-1:0] vec_mem [VEC_MEM_DEPTH];
   logic [MEM_DATAW-1:0] mat_mem [NUM_OLANES][MAT_MEM_DEPTH];

   state_e               state_q;
   logic                 busy_q, done_q;
   logic [VEC_ADDRW-1:0] vec_start_q, vec_ptr_q, vec_ptr_inc_c;
   logic [MAT_ADDRW-1:0] mat_ptr_q, mat_ptr_inc_c;
   logic [WCW-1:0]       num_words_q, w_q;
   logic [RCW-1:0]       num_rows_q, r_q;
   logic                 last_word_c, last_row_c, stall_c, pipe_empty_c;

   logic                 rd_vld_q, rd_first_q, rd_last_q;
   logic [MEM_DATAW-1:0] vec_rd_q;
   logic [MEM_DATAW-1:0] mat_rd_q [NUM_OLANES];

   logic                 mul_vld_q, mul_first_q, mul_last_q;
   logic signed [IWIDTH-1:0] vec_el_c [NUM_ELEMS];
   logic signed [IWIDTH-1:0] mat_el_c [NUM_OLANES][NUM_ELEMS];
   logic signed [PW-1:0]     prod_c   [NUM_OLANES][NUM_ELEMS];
   logic signed [PW-1:0]     mul_q    [NUM_OLANES][NUM_ELEMS];

   logic                 add_vld_q, add_first_q, add_last_q;
   logic signed [TW-1:0]     tree_c [NUM_OLANES];
   logic signed [TW-1:0]     add_q  [NUM_OLANES];

   logic signed [OWIDTH-1:0] acc_d  [NUM_OLANES];
   logic signed [OWIDTH-1:0] acc_q  [NUM_OLANES];
   logic signed [OWIDTH-1:0] res_q  [NUM_OLANES];
   logic                     valid_q;

   assign stall_c       = valid_q & ~i_ready;
   assign last_word_c   = (w_q == num_words_q - WCW'(1));
   assign last_row_c    = (r_q == num_rows_q - RCW'(1));
   assign pipe_empty_c  = ~rd_vld_q & ~mul_vld_q & ~add_vld_q;
   assign vec_ptr_inc_c = (vec_ptr_q == VEC_ADDRW'(VEC_MEM_DEPTH - 1)) ? '0 : vec_ptr_q + VEC_ADDRW'(1);
   assign mat_ptr_inc_c = (mat_ptr_q == MAT_ADDRW'(MAT_MEM_DEPTH - 1)) ? '0 : mat_ptr_q + MAT_ADDRW'(1);

   // Host write port; storage is never reset.
   always_ff @(posedge clk) begin
      if (i_vec_wen) vec_mem[i_vec_waddr] <= i_vec_wdata;
      for (int unsigned k = 0; k < NUM_OLANES; k++) begin
         if (i_mat_wen[k]) mat_mem[k][i_mat_waddr] <= i_mat_wdata;
      end
   end

   // Job control and issue sequencing; matrix pointer walks r*N+w contiguously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         vec_start_q <= '0;
         num_words_q <= '0;
         num_rows_q  <= '0;
         w_q         <= '0;
         r_q         <= '0;
         vec_ptr_q   <= '0;
         mat_ptr_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  vec_start_q <= i_vec_start_addr;
                  num_words_q <= i_vec_num_words;
                  num_rows_q  <= i_mat_num_rows_per_olane;
                  vec_ptr_q   <= i_vec_start_addr;
                  mat_ptr_q   <= i_mat_start_addr;
                  w_q         <= '0;
                  r_q         <= '0;
                  if (i_vec_num_words == '0 || i_mat_num_rows_per_olane == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q <= S_RUN;
                     busy_q  <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (!stall_c) begin
                  mat_ptr_q <= mat_ptr_inc_c;
                  if (last_word_c) begin
                     w_q       <= '0;
                     vec_ptr_q <= vec_start_q;
                     if (last_row_c) state_q <= S_DRAIN;
                     else            r_q     <= r_q + RCW'(1);
                  end else begin
                     w_q       <= w_q + WCW'(1);
                     vec_ptr_q <= vec_ptr_inc_c;
                  end
               end
            end
            S_DRAIN: begin
               if (pipe_empty_c && valid_q && i_ready) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Element unpack (element 0 in MSBs) and signed products.
   always_comb begin
      for (int unsigned e = 0; e < NUM_ELEMS; e++) begin
         vec_el_c[e] = vec_rd_q[(NUM_ELEMS-1-e)*IWIDTH +: IWIDTH];
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < NUM_OLANES; k++) begin
         for (int unsigned e = 0; e < NUM_ELEMS; e++) begin
            mat_el_c[k][e] = mat_rd_q[k][(NUM_ELEMS-1-e)*IWIDTH +: IWIDTH];
            prod_c[k][e]   = PW'(vec_el_c[e]) * PW'(mat_el_c[k][e]);
         end
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < NUM_OLANES; k++) begin
         tree_c[k] = '0;
         for (int unsigned e = 0; e < NUM_ELEMS; e++) begin
            tree_c[k] = tree_c[k] + TW'(mul_q[k][e]);
         end
      end
   end

`ifdef MVM_SAT_EN
   localparam int unsigned AW = ((TW > OWIDTH) ? TW : OWIDTH) + 1;
   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};

   logic signed [AW-1:0]  sum_c [NUM_OLANES];
   logic [NUM_OLANES-1:0] sat_q, sat_d;

   // Wide sum then clamp; once a lane hits a bound it holds there until the next row.
   always_comb begin
      for (int unsigned k = 0; k < NUM_OLANES; k++) begin
         sum_c[k] = AW'(add_q[k]);
         if (!add_first_q) sum_c[k] = sum_c[k] + AW'(acc_q[k]);
         sat_d[k] = 1'b1;
         if (!add_first_q && sat_q[k]) begin
            acc_d[k] = acc_q[k];
         end else if (sum_c[k] > SAT_MAX) begin
            acc_d[k] = OWIDTH'(SAT_MAX);
         end else if (sum_c[k] < SAT_MIN) begin
            acc_d[k] = OWIDTH'(SAT_MIN);
         end else begin
            acc_d[k] = OWIDTH'(sum_c[k]);
            sat_d[k] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                     sat_q <= '0;
      else if (!stall_c && add_vld_q) sat_q <= sat_d;
   end
`else
   always_comb begin
      for (int unsigned k = 0; k < NUM_OLANES; k++) begin
         acc_d[k] = OWIDTH'(add_q[k]);
         if (!add_first_q) acc_d[k] = acc_d[k] + acc_q[k];
      end
   end
`endif

   // Pipeline registers; every stage freezes while the output row is stalled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_vld_q    <= 1'b0;
         rd_first_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         mul_vld_q   <= 1'b0;
         mul_first_q <= 1'b0;
         mul_last_q  <= 1'b0;
         add_vld_q   <= 1'b0;
         add_first_q <= 1'b0;
         add_last_q  <= 1'b0;
         valid_q     <= 1'b0;
         vec_rd_q    <= '0;
         for (int unsigned k = 0; k < NUM_OLANES; k++) begin
            mat_rd_q[k] <= '0;
            add_q[k]    <= '0;
            acc_q[k]    <= '0;
            res_q[k]    <= '0;
            for (int unsigned e = 0; e < NUM_ELEMS; e++) mul_q[k][e] <= '0;
         end
      end else if (!stall_c) begin
         rd_vld_q    <= (state_q == S_RUN);
         rd_first_q  <= (w_q == '0);
         rd_last_q   <= last_word_c;
         vec_rd_q    <= vec_mem[vec_ptr_q];
         mul_vld_q   <= rd_vld_q;
         mul_first_q <= rd_first_q;
         mul_last_q  <= rd_last_q;
         add_vld_q   <= mul_vld_q;
         add_first_q <= mul_first_q;
         add_last_q  <= mul_last_q;
         valid_q     <= add_vld_q & add_last_q;
         for (int unsigned k = 0; k < NUM_OLANES; k++) begin
            mat_rd_q[k] <= mat_mem[k][mat_ptr_q];
            add_q[k]    <= tree_c[k];
            for (int unsigned e = 0; e < NUM_ELEMS; e++) mul_q[k][e] <= prod_c[k][e];
            if (add_vld_q)               acc_q[k] <= acc_d[k];
            if (add_vld_q && add_last_q) res_q[k] <= acc_d[k];
         end
      end
   end

   for (genvar k = 0; k < NUM_OLANES; k++) begin : g_out
      assign o_result[k*OWIDTH +: OWIDTH] = res_q[k];
   end

   assign o_busy  = busy_q;
   assign o_done  = done_q;
   assign o_valid = valid_q;

endmodule

// File: tb/tb_mvm_engine.sv
// Self-checking bench for mvm_engine (3 lanes, 16-bit results) against a dot-product reference model.
module tb_mvm_engine;

   localparam int NL = 3;
   localparam int OW = 16;
   localparam int NE = 8;
   localparam int IW = 8;
   localparam int VD = 16;
   localparam int MD = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic [63:0]   i_vec_wdata, i_mat_wdata;
   logic [3:0]    i_vec_waddr, i_vec_start_addr;
   logic [5:0]    i_mat_waddr, i_mat_start_addr;
   logic          i_vec_wen, i_start, i_ready;
   logic [2:0]    i_mat_wen;
   logic [4:0]    i_vec_num_words;
   logic [6:0]    i_mat_num_rows_per_olane;
   logic          o_busy, o_done, o_valid;
   logic [47:0]   o_result;

   int checks   = 0;
   int failures = 0;
   int vmem [VD][NE];
   int mmem [NL][MD][NE];
   logic [47:0] exp_q [$];

   mvm_engine #(.IWIDTH(IW), .OWIDTH(OW), .NUM_ELEMS(NE), .VEC_MEM_DEPTH(VD),
                .MAT_MEM_DEPTH(MD), .NUM_OLANES(NL)) dut (
      .clk(clk), .rst(rst),
      .i_vec_wdata(i_vec_wdata), .i_vec_waddr(i_vec_waddr), .i_vec_wen(i_vec_wen),
      .i_mat_wdata(i_mat_wdata), .i_mat_waddr(i_mat_waddr), .i_mat_wen(i_mat_wen),
      .i_start(i_start), .i_vec_start_addr(i_vec_start_addr), .i_vec_num_words(i_vec_num_words),
      .i_mat_start_addr(i_mat_start_addr), .i_mat_num_rows_per_olane(i_mat_num_rows_per_olane),
      .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done), .o_result(o_result), .o_valid(o_valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: per lane, per row, accumulate the dot products of wrapped-address words.
   task automatic build_golden(input int vs, input int n, input int ms, input int r);
      logic [47:0]       rowv;
      longint            acc, dot, s;
      bit                stuck;
      int                va, ma;
      logic signed [15:0] t;
      exp_q.delete();
      for (int row = 0; row < r; row++) begin
         rowv = '0;
         for (int k = 0; k < NL; k++) begin
            acc = 0;
            stuck = 0;
            for (int w = 0; w < n; w++) begin
               va = (vs + w) % VD;
               ma = (ms + row * n + w) % MD;
               dot = 0;
               for (int e = 0; e < NE; e++) dot += longint'(vmem[va][e] * mmem[k][ma][e]);
               s = acc + dot;
`ifdef MVM_SAT_EN
               if (!stuck) begin
                  if (s > 32767)       begin acc = 32767;  stuck = 1; end
                  else if (s < -32768) begin acc = -32768; stuck = 1; end
                  else                 acc = s;
               end
`else
               t = 16'(s);
               acc = longint'(t);
`endif
            end
            rowv[k*OW +: OW] = 16'(acc);
         end
         exp_q.push_back(rowv);
      end
   endtask

   task automatic fill_random();
      logic [63:0] vw, mw;
      int v;
      for (int a = 0; a < MD; a++) begin
         for (int k = 0; k < NL; k++) begin
            for (int e = 0; e < NE; e++) begin
               v = int'($urandom_range(15)) - 8;
               mmem[k][a][e] = v;
               mw[(NE-1-e)*IW +: IW] = 8'(v);
               v = int'($urandom_range(15)) - 8;
               if (k == 0 && a < VD) vmem[a][e] = v;
               vw[(NE-1-e)*IW +: IW] = 8'(v);
            end
            i_mat_wdata = mw;
            i_mat_waddr = 6'(a);
            i_mat_wen   = 3'(1 << k);
            i_vec_wdata = vw;
            i_vec_waddr = 4'(a);
            i_vec_wen   = (k == 0 && a < VD);
            tick();
            i_mat_wen = '0;
            i_vec_wen = 1'b0;
         end
      end
   endtask

   // Start a job and follow it to o_done, checking rows, stall stability, timing and completion.
   task automatic run_job(input int vs, input int n, input int ms, input int r,
                          input bit rand_ready, input bit chk_timing, input bit poke);
      int   row_idx, last_hs;
      bit   done_seen, prev_stall, rdy;
      logic [47:0] prev_res;
      row_idx = 0; last_hs = -10; done_seen = 0; prev_stall = 0; prev_res = '0;
      i_vec_start_addr = 4'(vs);
      i_vec_num_words  = 5'(n);
      i_mat_start_addr = 6'(ms);
      i_mat_num_rows_per_olane = 7'(r);
      i_ready = 1'b1;
      i_start = 1'b1;
      for (int cyc = 1; cyc <= 1000 && !done_seen; cyc++) begin
         tick();
         if (cyc == 1) begin
            i_start = 1'b0;
            checks++;
            if (o_busy !== 1'b1) begin
               failures++;
               $display("FAIL busy_after_start got=%b exp=1", o_busy);
            end
            i_vec_start_addr = 4'($urandom);
            i_vec_num_words  = 5'($urandom_range(1, 16));
            i_mat_start_addr = 6'($urandom);
            i_mat_num_rows_per_olane = 7'($urandom_range(1, 64));
         end
         if (poke) i_start = (cyc == 3);
         if (prev_stall) begin
            checks++;
            if (o_valid !== 1'b1 || o_result !== prev_res) begin
               failures++;
               $display("FAIL stall_hold valid=%b got=%h exp=%h", o_valid, o_result, prev_res);
            end
         end
         if (o_done === 1'b1) begin
            done_seen = 1;
            checks++;
            if (cyc != last_hs + 1 || o_busy !== 1'b0 || row_idx != r) begin
               failures++;
               $display("FAIL done_pulse cyc=%0d busy=%b rows=%0d exp_cyc=%0d exp_rows=%0d",
                        cyc, o_busy, row_idx, last_hs + 1, r);
            end
         end
         rdy = rand_ready ? 1'($urandom_range(1)) : 1'b1;
         i_ready = rdy;
         prev_stall = 0;
         if (o_valid === 1'b1) begin
            if (rdy) begin
               checks++;
               if (row_idx >= exp_q.size()) begin
                  failures++;
                  $display("FAIL extra_row idx=%0d got=%h exp=none", row_idx, o_result);
               end else if (o_result !== exp_q[row_idx]) begin
                  failures++;
                  $display("FAIL row_data idx=%0d got=%h exp=%h", row_idx, o_result, exp_q[row_idx]);
               end
               if (chk_timing) begin
                  checks++;
                  if (cyc != row_idx * n + n + 4) begin
                     failures++;
                     $display("FAIL row_timing idx=%0d got_cyc=%0d exp_cyc=%0d", row_idx, cyc, row_idx * n + n + 4);
                  end
               end
               row_idx++;
               last_hs = cyc;
            end else begin
               prev_stall = 1;
               prev_res = o_result;
            end
         end
      end
      i_start = 1'b0;
      i_ready = 1'b1;
      checks++;
      if (!done_seen) begin
         failures++;
         $display("FAIL job_timeout got=no_done exp=done rows=%0d", row_idx);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (o_valid !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL post_job_idle valid=%b done=%b busy=%b exp=000", o_valid, o_done, o_busy);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) tick();
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_valid !== 1'b0 || o_result !== 48'h0) begin
         failures++;
         $display("FAIL reset_values busy=%b done=%b valid=%b result=%h exp=0", o_busy, o_done, o_valid, o_result);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_result !== 48'h0) begin
         failures++;
         $display("FAIL after_reset busy=%b valid=%b result=%h exp=0", o_busy, o_valid, o_result);
      end
   endtask

   task automatic test_single_word_rows();
      int vs, ms;
      vs = int'($urandom_range(VD - 1));
      ms = int'($urandom_range(MD - 1));
      build_golden(vs, 1, ms, 3);
      run_job(vs, 1, ms, 3, 0, 1, 0);
   endtask

   task automatic test_wrap();
      build_golden(14, 2, 62, 4);
      run_job(14, 2, 62, 4, 0, 1, 0);
   endtask

   task automatic test_backpressure();
      int vs, ms;
      for (int i = 0; i < 2; i++) begin
         vs = int'($urandom_range(VD - 1));
         ms = int'($urandom_range(MD - 1));
         build_golden(vs, 2, ms, 4);
         run_job(vs, 2, ms, 4, 1, 0, 0);
      end
   endtask

   task automatic test_zero_length_and_ignore_start();
      for (int c = 0; c < 2; c++) begin
         i_vec_start_addr = 4'd0;
         i_mat_start_addr = 6'd0;
         i_vec_num_words  = (c == 0) ? 5'd0 : 5'd2;
         i_mat_num_rows_per_olane = (c == 0) ? 7'd3 : 7'd0;
         i_start = 1'b1;
         tick();
         i_start = 1'b0;
         checks++;
         if (o_done !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_done case=%0d done=%b busy=%b valid=%b exp=100", c, o_done, o_busy, o_valid);
         end
         for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (o_done !== 1'b0 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
               failures++;
               $display("FAIL zero_len_quiet case=%0d done=%b valid=%b busy=%b exp=000", c, o_done, o_valid, o_busy);
            end
         end
      end
      build_golden(7, 3, 33, 2);
      run_job(7, 3, 33, 2, 0, 1, 1);
   endtask

   task automatic test_reset_midrun();
      i_vec_start_addr = 4'd3;
      i_vec_num_words  = 5'd2;
      i_mat_start_addr = 6'd10;
      i_mat_num_rows_per_olane = 7'd4;
      i_ready = 1'b1;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      repeat (5) tick();
      checks++;
      if (o_valid !== 1'b1 || o_busy !== 1'b1) begin
         failures++;
         $display("FAIL midrun_active valid=%b busy=%b exp=11", o_valid, o_busy);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_valid !== 1'b0 || o_result !== 48'h0) begin
         failures++;
         $display("FAIL midrun_reset busy=%b done=%b valid=%b result=%h exp=0", o_busy, o_done, o_valid, o_result);
      end
      tick();
      checks++;
      if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_result !== 48'h0) begin
         failures++;
         $display("FAIL midrun_reset_hold busy=%b valid=%b result=%h exp=0", o_busy, o_valid, o_result);
      end
      rst = 1'b1;
      tick();
      build_golden(5, 3, 20, 3);
      run_job(5, 3, 20, 3, 0, 1, 0);
   endtask

   task automatic test_saturation();
      for (int a = 0; a < 4; a++) begin
         i_vec_wdata = {8{8'h80}};
         i_vec_waddr = 4'(a);
         i_vec_wen   = 1'b1;
         i_mat_wdata = {8{8'h80}};
         i_mat_waddr = 6'(a);
         i_mat_wen   = 3'b111;
         for (int e = 0; e < NE; e++) begin
            vmem[a][e] = -128;
            for (int k = 0; k < NL; k++) mmem[k][a][e] = -128;
         end
         tick();
         i_vec_wen = 1'b0;
         i_mat_wen = '0;
      end
      exp_q.delete();
`ifdef MVM_SAT_EN
      exp_q.push_back({3{16'h7fff}});
`else
      exp_q.push_back(48'h0);
`endif
      run_job(0, 4, 0, 1, 0, 1, 0);
   endtask

   task automatic test_random_jobs();
      int vs, ms, n, r;
      for (int i = 0; i < 4; i++) begin
         vs = int'($urandom_range(VD - 1));
         ms = int'($urandom_range(MD - 1));
         n  = int'($urandom_range(1, 4));
         r  = int'($urandom_range(1, 5));
         build_golden(vs, n, ms, r);
         run_job(vs, n, ms, r, 1, 0, 0);
      end
   endtask

   initial begin
      rst = 1'b0;
      i_vec_wdata = '0; i_vec_waddr = '0; i_vec_wen = 1'b0;
      i_mat_wdata = '0; i_mat_waddr = '0; i_mat_wen = '0;
      i_start = 1'b0; i_vec_start_addr = '0; i_vec_num_words = '0;
      i_mat_start_addr = '0; i_mat_num_rows_per_olane = '0; i_ready = 1'b1;
      test_reset();
      fill_random();
      test_single_word_rows();
      test_wrap();
      test_backpressure();
      test_zero_length_and_ignore_start();
      test_reset_midrun();
      test_random_jobs();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mvm_engine.md
# mvm_engine

Parametrised matrix-vector multiply engine, successor to the fixed 8-element MVM datapath. Holds one vector memory and one matrix memory per output lane, streams a vector of `N` words against `R` matrix rows per lane, and emits one `NUM_OLANES`-wide result row per `N` cycles. Generalises element count and lane count, and adds output backpressure (`i_ready`), a completion pulse and optional saturating accumulation. Sits between the host write port and the downstream result consumer.

## Interface
- `IWIDTH`, 8, signed element width.
- `OWIDTH`, 32, signed accumulator/result width; must be ≥ 2*IWIDTH+$clog2(NUM_ELEMS).
- `NUM_ELEMS`, 8, elements per memory word; `MEM_DATAW` = IWIDTH*NUM_ELEMS (derived, not overridable).
- `VEC_MEM_DEPTH`, 16, vector memory words; `VEC_ADDRW` = $clog2(VEC_MEM_DEPTH).
- `MAT_MEM_DEPTH`, 64, words per lane matrix memory; `MAT_ADDRW` = $clog2(MAT_MEM_DEPTH).
- `NUM_OLANES`, 4, output lanes (≥1).
- `clk  input  1  single clock, all logic on rising edge`
- `rst  input  1  asynchronous, active-low reset`
- `i_vec_wdata  input  MEM_DATAW  vector write data; element 0 in MSBs`
- `i_vec_waddr  input  VEC_ADDRW  vector write address`
- `i_vec_wen  input  1  vector write enable`
- `i_mat_wdata  input  MEM_DATAW  matrix write data; element 0 in MSBs`
- `i_mat_waddr  input  MAT_ADDRW  matrix write address`
- `i_mat_wen  input  NUM_OLANES  per-lane matrix write enable (any combination)`
- `i_start  input  1  start request, sampled in IDLE only`
- `i_vec_start_addr  input  VEC_ADDRW  first vector word`
- `i_vec_num_words  input  VEC_ADDRW+1  N, words per row`
- `i_mat_start_addr  input  MAT_ADDRW  first matrix word (same in all lanes)`
- `i_mat_num_rows_per_olane  input  MAT_ADDRW+1  R, rows per lane`
- `i_ready  input  1  downstream accepts result row`
- `o_busy  output  1  job in progress`
- `o_done  output  1  one-cycle pulse after last row accepted`
- `o_result  output  NUM_OLANES*OWIDTH  lane k at bits [k*OWIDTH +: OWIDTH], signed`
- `o_valid  output  1  o_result holds a row`

## Operation
- FSM: IDLE → RUN (all N·R words issued) → DRAIN (pipeline empty and last row accepted) → IDLE. Reset state IDLE.
- IDLE with `i_start`=1: latch all four config inputs; if N=0 or R=0, go straight to pulse `o_done` next cycle, no `o_valid`. Otherwise enter RUN. `i_start` outside IDLE ignored; config changes after start ignored.
- Issue index (r,w): vec addr = vec_start+w, mat addr = mat_start+r*N+w, both modulo depth (wrap).
- Pipeline: memory read (1) → NUM_ELEMS signed products, registered (1) → adder tree, registered (1) → accumulate (1). Accumulator clears on w=0, row result moves to output register on w=N-1.
- Widths: products 2*IWIDTH, tree 2*IWIDTH+$clog2(NUM_ELEMS), sign-extended into OWIDTH accumulator; default two's-complement wrap.
- Backpressure: stall = `o_valid` & !`i_ready`. While stalled every pipeline stage, memory read register and issue counter hold; no data lost or duplicated. `o_valid` drops after handshake unless a new row loads same cycle.
- Memory writes are accepted every cycle, in any state; a write to an address being read in the same cycle returns old data.
- Reset (any time, incl. mid-job): FSM IDLE, counters/pipeline cleared; memory contents not cleared.

## Timing
- Reset values: `o_busy`=0, `o_done`=0, `o_valid`=0, `o_result`=0.
- `i_start` high at edge 0 → `o_busy`=1 from cycle 1; word (r,w) issued cycle 1+r·N+w (no stall).
- Row r `o_valid` first high in cycle r·N+N+4 (N=1,r=0: cycle 5). Throughput 1 row/N cycles; N=1 back-to-back rows.
- Each stall cycle delays all later events by one.
- `o_done` high exactly one cycle, the cycle after the last row's handshake; `o_busy` low in that same cycle; new `i_start` accepted from that cycle.

## Configuration
- `MVM_SAT_EN` defined: accumulator add saturates to [−2^(OWIDTH−1), 2^(OWIDTH−1)−1] per step and sticks at the bound until cleared for next row. Undefined: two's-complement wrap modulo 2^OWIDTH.

## Test plan
- N=1,R=3, NUM_OLANES=3, random elements in [−8,7], `i_ready`=1 → 3 rows equal to golden dot products, first `o_valid` at cycle 5, `o_done` once.
- N=2,R=4, vec_start=14, mat_start=62 (depths 16/64) → addresses wrap, results match golden wrapped-address model.
- N=2,R=4 with `i_ready` toggled pseudo-randomly (50%) → identical results in order, `o_result` stable while `o_valid`&!`i_ready`.
- All elements −128, OWIDTH=16, N=4 → without macro wrap value (4·8·16384 mod 2^16 = 0); with `MVM_SAT_EN` result 32767.
- N=0 start → `o_done` pulse cycle 1, no `o_valid`; `i_start` during RUN ignored.
- `rst` low mid-RUN → all outputs 0 next cycle; fresh job afterwards uses preserved memory and matches golden.
